// File: rtl/qam_mod_pkg.sv
// Shared QAM-16 definitions: level type, Gray mapping constants and
// mapping functions, and the transmit pacer state encoding. The mapping
// here is the exact inverse of the receive-side hard-decision demapper,
// which slices at 0 and +/-2.
package qam_mod_pkg;

  typedef logic signed [2:0] qam_level_t;

  localparam qam_level_t LVL_N3   = 3'b101;  // -3
  localparam qam_level_t LVL_N1   = 3'b111;  // -1
  localparam qam_level_t LVL_ZERO = 3'b000;
  localparam qam_level_t LVL_P1   = 3'b001;  // +1
  localparam qam_level_t LVL_P3   = 3'b011;  // +3

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } qam_mod_state_t;

  // In-phase Gray map: 00,01,11,10 -> -3,-1,+1,+3
  function automatic qam_level_t map_i(input logic [1:0] bits);
    case (bits)
      2'b00:   map_i = LVL_N3;
      2'b01:   map_i = LVL_N1;
      2'b11:   map_i = LVL_P1;
      2'b10:   map_i = LVL_P3;
      default: map_i = LVL_ZERO;
    endcase
  endfunction

  // Quadrature Gray map: 00,01,11,10 -> +3,+1,-1,-3
  function automatic qam_level_t map_q(input logic [1:0] bits);
    case (bits)
      2'b00:   map_q = LVL_P3;
      2'b01:   map_q = LVL_P1;
      2'b11:   map_q = LVL_N1;
      2'b10:   map_q = LVL_N3;
      default: map_q = LVL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/qam_mod_if.sv
// Sample stream from the QAM mapper to the transmit shaping filter.
interface qam_internal_port;
  import qam_mod_pkg::*;

  logic       valid;
  qam_level_t i;
  qam_level_t q;

  modport pout (output valid, output i, output q);
  modport pin  (input  valid, input  i, input  q);
endinterface

// File: rtl/qam_sym_fifo.sv
// Small synchronous symbol FIFO with first-word fall-through read.
// Pushes are ignored while full and pops while empty.
module qam_sym_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic [LW-1:0]    count_next_s;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full_r;
  assign pop_ok_s  = pop && (count_r != LW'(0));
  assign dout      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = (count_r == LW'(0));
  assign level     = count_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + LW'(1);
      2'b01:   count_next_s = count_r - LW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage, pointers, occupancy and registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_r[k] <= {WIDTH{1'b0}};
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= LW'(0);
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == LW'(DEPTH));
    end
  end
endmodule

// File: rtl/qam_mod.sv
// QAM-16 transmit mapper and symbol-rate pacer. Buffers 4-bit symbols,
// maps each to an I/Q level pair on phase 0 of an SPS-sample period and
// zero-stuffs the remaining phases. On starvation it emits FLUSH_SYMS
// periods of zeros before going idle.
module qam_mod
  import qam_mod_pkg::*;
#(
  parameter int SPS        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int FLUSH_SYMS = 8
) (
  input  logic                              axi_clk,
  input  logic                              axi_rstn,
  input  logic                              din_valid,
  input  logic [3:0]                        din,
  output logic                              din_ready,
  qam_internal_port.pout                    mod,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                       underflow_cnt
);
  localparam int PW = $clog2(SPS);
  localparam int GW = $clog2(FLUSH_SYMS+1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SPS-1);
  localparam logic [GW-1:0] GAP_DONE   = GW'(FLUSH_SYMS);

  qam_mod_state_t state_r;
  logic [PW-1:0]  phase_r;
  logic [GW-1:0]  gap_r;
  logic           valid_r;
  qam_level_t     i_r;
  qam_level_t     q_r;
  logic [15:0]    ucnt_r;

  logic           full_s;
  logic           empty_s;
  logic           pop_s;
  logic [3:0]     sym_s;
  logic [PW-1:0]  phase_next_s;

  qam_sym_fifo #(.WIDTH(4), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (axi_clk),
    .rst_n (axi_rstn),
    .push  (din_valid),
    .pop   (pop_s),
    .din   (din),
    .dout  (sym_s),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  assign din_ready     = !full_s;
  assign mod.valid     = valid_r;
  assign mod.i         = i_r;
  assign mod.q         = q_r;
  assign underflow_cnt = ucnt_r;
  assign phase_next_s  = (phase_r == PHASE_LAST) ? PW'(0) : phase_r + PW'(1);

  // Pop only at a symbol boundary while transmitting and data is waiting.
  always_comb begin
    pop_s = 1'b0;
    if ((state_r != IDLE) && (phase_r == PW'(0)) && !empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Pacer FSM with registered sample outputs and starvation accounting.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_r <= IDLE;
      phase_r <= PW'(0);
      gap_r   <= GW'(0);
      valid_r <= 1'b0;
      i_r     <= LVL_ZERO;
      q_r     <= LVL_ZERO;
      ucnt_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          i_r     <= LVL_ZERO;
          q_r     <= LVL_ZERO;
          phase_r <= PW'(0);
          gap_r   <= GW'(0);
          state_r <= empty_s ? IDLE : RUN;
        end
        RUN: begin
          valid_r <= 1'b1;
          phase_r <= phase_next_s;
          if ((phase_r == PW'(0)) && !empty_s) begin
            i_r <= map_i(sym_s[3:2]);
            q_r <= map_q(sym_s[1:0]);
          end else if (phase_r == PW'(0)) begin
            i_r     <= LVL_ZERO;
            q_r     <= LVL_ZERO;
            ucnt_r  <= (ucnt_r == 16'hFFFF) ? ucnt_r : ucnt_r + 16'd1;
            gap_r   <= GW'(1);
            state_r <= FLUSH;
          end else begin
            i_r <= LVL_ZERO;
            q_r <= LVL_ZERO;
          end
        end
        FLUSH: begin
          valid_r <= 1'b1;
          phase_r <= phase_next_s;
          if ((phase_r == PW'(0)) && !empty_s) begin
            i_r     <= map_i(sym_s[3:2]);
            q_r     <= map_q(sym_s[1:0]);
            gap_r   <= GW'(0);
            state_r <= RUN;
          end else if (phase_r == PW'(0)) begin
            i_r    <= LVL_ZERO;
            q_r    <= LVL_ZERO;
            ucnt_r <= (ucnt_r == 16'hFFFF) ? ucnt_r : ucnt_r + 16'd1;
            gap_r  <= gap_r + GW'(1);
          end else if ((phase_r == PHASE_LAST) && (gap_r == GAP_DONE)) begin
            i_r     <= LVL_ZERO;
            q_r     <= LVL_ZERO;
            phase_r <= PW'(0);
            state_r <= IDLE;
          end else begin
            i_r <= LVL_ZERO;
            q_r <= LVL_ZERO;
          end
        end
        default: begin
          state_r <= IDLE;
          phase_r <= PW'(0);
          gap_r   <= GW'(0);
          valid_r <= 1'b0;
          i_r     <= LVL_ZERO;
          q_r     <= LVL_ZERO;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qam_mod.sv
// Directed, table-driven bench for qam_mod with SPS=4, FIFO_DEPTH=8,
// FLUSH_SYMS=8.
module tb_qam_mod;
  logic        axi_clk = 1'b0;
  logic        axi_rstn;
  logic        din_valid;
  logic [3:0]  din;
  logic        din_ready;
  logic [3:0]  fifo_level;
  logic [15:0] underflow_cnt;

  qam_internal_port mod_if();

  qam_mod #(.SPS(4), .FIFO_DEPTH(8), .FLUSH_SYMS(8)) dut (
    .axi_clk       (axi_clk),
    .axi_rstn      (axi_rstn),
    .din_valid     (din_valid),
    .din           (din),
    .din_ready     (din_ready),
    .mod           (mod_if),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt)
  );

  always #5 axi_clk = ~axi_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] nib;
    int         ei;
    int         eq;
  } vec_t;
  vec_t vecs[16];

  int got, last, nv, nz;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  // Reference hard-decision demapper (receive side).
  function automatic logic [1:0] demap_i(input int v);
    if (v < -2)     demap_i = 2'b00;
    else if (v < 0) demap_i = 2'b01;
    else if (v < 2) demap_i = 2'b11;
    else            demap_i = 2'b10;
  endfunction

  function automatic logic [1:0] demap_q(input int v);
    if (v >= 2)       demap_q = 2'b00;
    else if (v >= 0)  demap_q = 2'b01;
    else if (v >= -2) demap_q = 2'b11;
    else              demap_q = 2'b10;
  endfunction

  task automatic do_reset();
    @(negedge axi_clk);
    axi_rstn  = 1'b0;
    din_valid = 1'b0;
    din       = 4'h0;
    repeat (2) @(negedge axi_clk);
    axi_rstn = 1'b1;
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk_level(input string nm, input int ei, input int eq);
    chk({nm, "_valid"}, int'(mod_if.valid), 1);
    chk({nm, "_i"}, int'(mod_if.i), ei);
    chk({nm, "_q"}, int'(mod_if.q), eq);
  endtask

  // Counts valid samples (and non-zero ones) until mod.valid drops.
  task automatic wait_idle(input int limit, output int n_valid, output int n_nonzero);
    bit done;
    done = 1'b0;
    n_valid = 0;
    n_nonzero = 0;
    for (int c = 0; c < limit; c++) begin
      if (!mod_if.valid) begin
        done = 1'b1;
        break;
      end
      n_valid++;
      if (mod_if.i != 0 || mod_if.q != 0) n_nonzero++;
      tick(1);
    end
    chk("idle_reached", int'(done), 1);
  endtask

  task automatic push1(input logic [3:0] v);
    din = v;
    din_valid = 1'b1;
    tick(1);
    din_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b0000, -3,  3};
    vecs[1]  = '{4'b0001, -3,  1};
    vecs[2]  = '{4'b0010, -3, -3};
    vecs[3]  = '{4'b0011, -3, -1};
    vecs[4]  = '{4'b0100, -1,  3};
    vecs[5]  = '{4'b0101, -1,  1};
    vecs[6]  = '{4'b0110, -1, -3};
    vecs[7]  = '{4'b0111, -1, -1};
    vecs[8]  = '{4'b1000,  3,  3};
    vecs[9]  = '{4'b1001,  3,  1};
    vecs[10] = '{4'b1010,  3, -3};
    vecs[11] = '{4'b1011,  3, -1};
    vecs[12] = '{4'b1100,  1,  3};
    vecs[13] = '{4'b1101,  1,  1};
    vecs[14] = '{4'b1110,  1, -3};
    vecs[15] = '{4'b1111,  1, -1};

    axi_rstn = 1'b0; din_valid = 1'b0; din = 4'h0;
    do_reset();

    // Reset state
    chk("rst_valid", int'(mod_if.valid), 0);
    chk("rst_i", int'(mod_if.i), 0);
    chk("rst_q", int'(mod_if.q), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ucnt", int'(underflow_cnt), 0);
    chk("rst_ready", int'(din_ready), 1);

    // Single symbol: 2-cycle latency, zero stuffing, first underflow
    push1(4'b0000);                       // edge k
    chk("t1_level_push", int'(fifo_level), 1);
    chk("t1_k_valid", int'(mod_if.valid), 0);
    tick(1);                              // k+1: RUN, output still idle
    chk("t1_k1_valid", int'(mod_if.valid), 0);
    tick(1);                              // k+2
    chk_level("t1_sym", -3, 3);
    chk("t1_level_pop", int'(fifo_level), 0);
    for (int p = 1; p < 4; p++) begin
      tick(1);
      chk_level("t1_zero", 0, 0);
    end
    chk("t1_ucnt_before", int'(underflow_cnt), 0);
    tick(1);                              // k+6: starved phase 0
    chk_level("t1_starve", 0, 0);
    chk("t1_ucnt_after", int'(underflow_cnt), 1);

    // All 16 nibbles back-to-back
    do_reset();
    got = 0; last = 0;
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          bit ok;
          ok = 1'b0;
          din = vecs[n].nib;
          din_valid = 1'b1;
          for (int w = 0; w < 64; w++) begin
            @(negedge axi_clk);
            if (din_ready) begin
              ok = 1'b1;
              break;
            end
          end
          chk("t2_push_ok", int'(ok), 1);
          @(posedge axi_clk);
          #1;
        end
        din_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 300 && got < 16; c++) begin
          @(negedge axi_clk);
          if (mod_if.valid && (mod_if.i != 0 || mod_if.q != 0)) begin
            if (got > 0) chk("t2_spacing", c - last, 4);
            chk("t2_i", int'(mod_if.i), vecs[got].ei);
            chk("t2_q", int'(mod_if.q), vecs[got].eq);
            chk("t2_roundtrip",
                int'({demap_i(int'(mod_if.i)), demap_q(int'(mod_if.q))}),
                int'(vecs[got].nib));
            last = c;
            got++;
          end
        end
      end
    join
    chk("t2_count", got, 16);
    chk("t2_no_underflow_yet", int'(underflow_cnt) <= 1 ? 1 : 0, 1);

    // Fill to full; a full FIFO refuses a push even on a pop edge
    do_reset();
    din = 4'h5;
    din_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (fifo_level == 4'd8) break;
      tick(1);
    end
    chk("t3_full_level", int'(fifo_level), 8);
    chk("t3_full_ready", int'(din_ready), 0);
    for (int c = 0; c < 6; c++) begin
      if (fifo_level != 4'd8) break;
      tick(1);
    end
    chk("t3_pop_no_push", int'(fifo_level), 7);
    chk("t3_ready_again", int'(din_ready), 1);
    tick(1);
    chk("t3_refill", int'(fifo_level), 8);
    din_valid = 1'b0;

    // Three symbols then starvation: 3 + 32 zero samples, then idle
    do_reset();
    push1(4'b1011);
    push1(4'b0110);
    push1(4'b1111);                       // now at k+2
    chk_level("t4_s0", 3, -1);
    tick(4);
    chk_level("t4_s1", -1, -3);
    tick(4);
    chk_level("t4_s2", 1, -1);
    tick(1);
    wait_idle(80, nv, nz);
    chk("t4_zero_samples", nv, 35);
    chk("t4_nonzero", nz, 0);
    chk("t4_ucnt", int'(underflow_cnt), 8);
    tick(6);
    chk("t4_idle_valid", int'(mod_if.valid), 0);
    chk("t4_idle_ucnt", int'(underflow_cnt), 8);

    // Symbol arriving in FLUSH gap 3 resumes at the next phase 0
    do_reset();
    push1(4'b1001);                       // k
    tick(2);                              // k+2
    chk_level("t5_s0", 3, 1);
    tick(12);                             // k+14: third starved phase 0
    chk_level("t5_gap3", 0, 0);
    chk("t5_ucnt_gap3", int'(underflow_cnt), 3);
    push1(4'b0100);                       // k+15
    tick(2);                              // k+17
    chk_level("t5_gap3_tail", 0, 0);
    tick(1);                              // k+18
    chk_level("t5_resume", -1, 3);
    chk("t5_ucnt_resume", int'(underflow_cnt), 3);
    tick(1);
    wait_idle(80, nv, nz);
    chk("t5_zero_samples", nv, 35);
    chk("t5_ucnt_final", int'(underflow_cnt), 11);

    // Asynchronous reset mid-symbol with 5 queued symbols
    do_reset();
    din = 4'h3;
    din_valid = 1'b1;
    tick(7);                              // pushes on k..k+6, pops k+2, k+6
    din_valid = 1'b0;
    tick(1);                              // k+7: phase 2
    chk("t6_level_pre", int'(fifo_level), 5);
    chk_level("t6_pre", 0, 0);
    #2;
    axi_rstn = 1'b0;
    #1;
    chk("t6_async_valid", int'(mod_if.valid), 0);
    chk("t6_async_level", int'(fifo_level), 0);
    chk("t6_async_i", int'(mod_if.i), 0);
    repeat (2) @(negedge axi_clk);
    axi_rstn = 1'b1;
    @(posedge axi_clk);
    #1;
    chk("t6_post_level", int'(fifo_level), 0);
    chk("t6_post_ready", int'(din_ready), 1);
    tick(3);
    chk("t6_post_idle", int'(mod_if.valid), 0);
    push1(4'b1110);                       // k
    tick(1);                              // k+1
    chk("t6_lat_k1", int'(mod_if.valid), 0);
    tick(1);                              // k+2
    chk_level("t6_lat_k2", 1, -3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
